game_state_ctrl: RTL and testbench

//   Top-level game-flow controller. Generates the one-hot screen-state flags
//   (is_menu/is_playing/is_continue/is_final) consumed by the RGB render stage.

---
 rtl/game_state_ctrl.sv | 158 +++++++++++++++
 tb/tb_game_state_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Game-flow controller: one-hot screen flags, lives/level/outcome bookkeeping
// and frame-based timing of the continue and final screens.
module game_state_ctrl #(
  parameter  int LIVES_INIT   = 3,
  parameter  int NUM_LEVELS   = 4,
  parameter  int CONT_TIMEOUT = 600,
  parameter  int FINAL_HOLD   = 300,
  localparam int LW           = $clog2(LIVES_INIT + 1),
  localparam int VW           = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          frame_tick_i,
  input  logic          start_btn_i,
  input  logic          player_hit_i,
  input  logic          level_clear_i,
  output logic          is_menu_o,
  output logic          is_playing_o,
  output logic          is_continue_o,
  output logic          is_final_o,
  output logic [LW-1:0] lives_o,
  output logic [VW-1:0] level_o,
  output logic          win_o,
  output logic          game_reset_o
);

  localparam int TMAX = (CONT_TIMEOUT > FINAL_HOLD) ? CONT_TIMEOUT : FINAL_HOLD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [LW-1:0] LIVES_LD = LW'(LIVES_INIT);
  localparam logic [LW-1:0] LIVES_1  = LW'(1);
  localparam logic [VW-1:0] LAST_LVL = VW'(NUM_LEVELS - 1);
  localparam logic [TW-1:0] CONT_T   = TW'(CONT_TIMEOUT);
  localparam logic [TW-1:0] HOLD_T   = TW'(FINAL_HOLD);

  // One-hot encoding maps straight onto the four screen flags.
  typedef enum logic [3:0] {
    S_MENU  = 4'b0001,
    S_PLAY  = 4'b0010,
    S_CONT  = 4'b0100,
    S_FINAL = 4'b1000
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   lives_q, lives_d;
  logic [VW-1:0]   level_q, level_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            win_q, win_d;
  logic            game_reset_q, game_reset_d;
  logic            start_q;

  logic            start_edge;
  logic            last_lvl;
  logic            cont_done;
  logic            hold_done;
  logic [TW-1:0]   timer_inc;

  assign start_edge = start_btn_i & ~start_q;
  assign last_lvl   = (level_q == LAST_LVL);
  assign timer_inc  = timer_q + TW'(1);
  assign cont_done  = frame_tick_i & (timer_inc == CONT_T);
  assign hold_done  = (timer_q == HOLD_T);

  // start_q resets high so a button held through reset is not an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_MENU;
      lives_q      <= LIVES_LD;
      level_q      <= '0;
      win_q        <= 1'b0;
      timer_q      <= '0;
      game_reset_q <= 1'b0;
      start_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      win_q        <= win_d;
      timer_q      <= timer_d;
      game_reset_q <= game_reset_d;
      start_q      <= start_btn_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MENU:  if (start_edge) state_d = S_PLAY;
      S_PLAY: begin
        if (level_clear_i)                           state_d = last_lvl ? S_FINAL : S_CONT;
        else if (player_hit_i && lives_q <= LIVES_1) state_d = S_FINAL;
      end
      S_CONT:  if (start_edge || cont_done) state_d = S_PLAY;
      S_FINAL: if (start_edge && hold_done) state_d = S_MENU;
      default: state_d = S_MENU;
    endcase
  end

  // Timer is held at zero outside CONTINUE/FINAL, so it is clear on entry.
  always_comb begin
    lives_d      = lives_q;
    level_d      = level_q;
    win_d        = win_q;
    timer_d      = timer_q;
    game_reset_d = 1'b0;
    case (state_q)
      S_MENU: begin
        timer_d = '0;
        if (start_edge) begin
          lives_d      = LIVES_LD;
          level_d      = '0;
          win_d        = 1'b0;
          game_reset_d = 1'b1;
        end
      end
      S_PLAY: begin
        timer_d = '0;
        if (level_clear_i) begin
          if (last_lvl) win_d   = 1'b1;
          else          level_d = level_q + VW'(1);
        end else if (player_hit_i) begin
          if (lives_q <= LIVES_1) begin
            lives_d = '0;
            win_d   = 1'b0;
          end else begin
            lives_d      = lives_q - LW'(1);
            game_reset_d = 1'b1;
          end
        end
      end
      S_CONT: begin
        if (start_edge || cont_done) begin
          timer_d      = '0;
          game_reset_d = 1'b1;
        end else if (frame_tick_i) begin
          timer_d = timer_inc;
        end
      end
      S_FINAL: begin
        if (start_edge && hold_done)        timer_d = '0;
        else if (frame_tick_i && !hold_done) timer_d = timer_inc;
      end
      default: begin
        lives_d = LIVES_LD;
        level_d = '0;
        win_d   = 1'b0;
        timer_d = '0;
      end
    endcase
  end

  assign {is_final_o, is_continue_o, is_playing_o, is_menu_o} = state_q;
  assign lives_o      = lives_q;
  assign level_o      = level_q;
  assign win_o        = win_q;
  assign game_reset_o = game_reset_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios then random play, every cycle
// compared against a screen/lives/level model built from the game rules.
module tb_game_state_ctrl;

  localparam int LIVES_INIT   = 3;
  localparam int NUM_LEVELS   = 4;
  localparam int CONT_TIMEOUT = 600;
  localparam int FINAL_HOLD   = 300;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       frame_tick_i, start_btn_i, player_hit_i, level_clear_i;
  logic       is_menu_o, is_playing_o, is_continue_o, is_final_o;
  logic [1:0] lives_o, level_o;
  logic       win_o, game_reset_o;

  int checks = 0;
  int errors = 0;

  // Model: screen 0=menu 1=playing 2=continue 3=final
  int m_screen, m_lives, m_level, m_win, m_frames, m_reset;
  bit m_prev_start;

  game_state_ctrl #(
    .LIVES_INIT(LIVES_INIT), .NUM_LEVELS(NUM_LEVELS),
    .CONT_TIMEOUT(CONT_TIMEOUT), .FINAL_HOLD(FINAL_HOLD)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .frame_tick_i(frame_tick_i),
    .start_btn_i(start_btn_i), .player_hit_i(player_hit_i),
    .level_clear_i(level_clear_i), .is_menu_o(is_menu_o),
    .is_playing_o(is_playing_o), .is_continue_o(is_continue_o),
    .is_final_o(is_final_o), .lives_o(lives_o), .level_o(level_o),
    .win_o(win_o), .game_reset_o(game_reset_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected to be done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int flags;
    flags = {28'd0, is_final_o, is_continue_o, is_playing_o, is_menu_o};
    chk("screen_flags", flags, 1 << m_screen);
    chk("lives", int'(lives_o), m_lives);
    chk("level", int'(level_o), m_level);
    chk("win", int'(win_o), m_win);
    chk("game_reset", int'(game_reset_o), m_reset);
  endtask

  task automatic model_reset();
    m_screen = 0; m_lives = LIVES_INIT; m_level = 0; m_win = 0;
    m_frames = 0; m_reset = 0; m_prev_start = 1'b1;
  endtask

  task automatic model_step(input bit tick, input bit st, input bit hit, input bit clr);
    bit pressed;
    pressed      = st && !m_prev_start;
    m_prev_start = st;
    m_reset      = 0;
    case (m_screen)
      0: if (pressed) begin
        m_screen = 1; m_lives = LIVES_INIT; m_level = 0; m_win = 0; m_reset = 1;
      end
      1: begin
        if (clr) begin
          m_frames = 0;
          if (m_level == NUM_LEVELS - 1) begin m_screen = 3; m_win = 1; end
          else begin m_level++; m_screen = 2; end
        end else if (hit) begin
          if (m_lives == 1) begin m_lives = 0; m_screen = 3; m_win = 0; m_frames = 0; end
          else begin m_lives--; m_reset = 1; end
        end
      end
      2: begin
        if (tick) m_frames++;
        if (pressed || m_frames == CONT_TIMEOUT) begin m_screen = 1; m_reset = 1; end
      end
      default: begin
        if (pressed && m_frames >= FINAL_HOLD) m_screen = 0;
        else if (tick && m_frames < FINAL_HOLD) m_frames++;
      end
    endcase
  endtask

  task automatic cyc(input bit tick, input bit st, input bit hit, input bit clr);
    frame_tick_i = tick; start_btn_i = st; player_hit_i = hit; level_clear_i = clr;
    @(posedge clk_i);
    model_step(tick, st, hit, clr);
    #1;
    check_all();
    frame_tick_i = 1'b0; player_hit_i = 1'b0; level_clear_i = 1'b0;
  endtask

  task automatic press();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    rst_ni = 1'b0; start_btn_i = 1'b1;
    frame_tick_i = 1'b0; player_hit_i = 1'b0; level_clear_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1 check_all();
    @(negedge clk_i) rst_ni = 1'b1;

    // start held through reset never starts a game
    repeat (5) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    press();
    chk("start_lives", int'(lives_o), LIVES_INIT);

    // lose all lives
    repeat (3) begin cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); end
    chk("lose_final", int'(is_final_o), 1);
    chk("lose_win", int'(win_o), 0);

    // final hold: press at frame 299 ignored, after 300 returns to menu
    repeat (FINAL_HOLD - 1) cyc(1, 0, 0, 0);
    press();
    chk("hold_ignored", int'(is_final_o), 1);
    repeat (5) cyc(1, 0, 0, 0);
    press();
    chk("back_to_menu", int'(is_menu_o), 1);

    // clear levels, early press, full timeout, then win
    press();
    cyc(0, 0, 0, 1);
    repeat (10) cyc(1, 0, 0, 0);
    press();
    chk("early_resume", int'(is_playing_o), 1);
    cyc(0, 0, 0, 1);
    repeat (CONT_TIMEOUT - 1) cyc(1, 0, 0, 0);
    chk("still_cont", int'(is_continue_o), 1);
    cyc(1, 0, 0, 0);
    chk("auto_resume", int'(is_playing_o), 1);
    cyc(0, 0, 0, 1);
    press();
    cyc(0, 0, 0, 1);
    chk("win_final", int'(win_o), 1);
    repeat (FINAL_HOLD) cyc(1, 0, 0, 0);
    press();

    // simultaneous hit and clear at level 1, lives 1
    press();
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    press();
    cyc(0, 0, 1, 1);
    chk("prio_level", int'(level_o), 2);
    chk("prio_lives", int'(lives_o), 1);
    press();

    // async reset mid-play
    #3 rst_ni = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk_i) rst_ni = 1'b1;

    // random play
    for (int i = 0; i < 6000; i++) begin
      cyc(($urandom % 2) == 0, ($urandom % 6) == 0,
          ($urandom % 20) == 0, ($urandom % 25) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
